// File: rtl/splitmix64_gen_if.sv
// -----------------------------------------------------------------------------
// splitmix64_gen_if
//   Bundle of the control and output-stream signals of splitmix64_gen.
//
//   seed_load  : load seed_in into the generator state and flush the pipeline
//   seed_in    : 64-bit seed value
//   run        : allow new beats to be issued
//   out_ready  : consumer accepts the current beat
//   out_valid  : out_data holds a valid beat
//   out_data   : LANES x 64-bit words, lane i at [64*i+63:64*i], lane 0 oldest
//   out_count  : number of accepted beats, wraps at 2^32
//
//   Handshake: a beat transfers on every rising clock edge where out_valid and
//   out_ready are both high. While out_valid is high and out_ready is low the
//   producer keeps out_valid and out_data unchanged (except that seed_load
//   discards the pending beat). out_valid never waits for out_ready.
//
//   master : generator side
//   slave  : consumer/controller side
// -----------------------------------------------------------------------------
interface splitmix64_gen_if #(
    parameter int LANES = 1
);
    logic                seed_load;
    logic [63:0]         seed_in;
    logic                run;
    logic                out_ready;
    logic                out_valid;
    logic [64*LANES-1:0] out_data;
    logic [31:0]         out_count;

    modport master (
        input  seed_load, seed_in, run, out_ready,
        output out_valid, out_data, out_count
    );

    modport slave (
        output seed_load, seed_in, run, out_ready,
        input  out_valid, out_data, out_count
    );
endinterface

// File: rtl/splitmix64_gen.sv
// -----------------------------------------------------------------------------
// splitmix64_gen
//   Self-contained SplitMix64 generator. Holds a 64-bit state, produces LANES
//   consecutive SplitMix64 words per beat on a valid/ready stream with full
//   backpressure. The mixer is either one combinational stage (PIPELINED=0,
//   latency 1) or three register stages (PIPELINED=1, latency 3).
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : splitmix64_gen_if.master (seed_load, seed_in, run, out_ready,
//              out_valid, out_data, out_count)
//
//   Parameters:
//     LANES        : words per beat (1..4), must match the interface LANES
//     PIPELINED    : 0 = single-stage mixer, 1 = three-stage mixer
//     GAMMA        : state increment per generated word
//     SEED_DEFAULT : state value after reset
// -----------------------------------------------------------------------------
module splitmix64_gen #(
    parameter int          LANES        = 1,
    parameter int          PIPELINED    = 0,
    parameter logic [63:0] GAMMA        = 64'h9e3779b97f4a7c15,
    parameter logic [63:0] SEED_DEFAULT = 64'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    splitmix64_gen_if.master bus
);

    localparam int          W    = 64 * LANES;
    // State advance for one whole beat.
    localparam logic [63:0] STEP = GAMMA * 64'(LANES);

    // ---------------------------------------------------------------------
    // Mixer steps; each one is a single pipeline stage when PIPELINED=1.
    // ---------------------------------------------------------------------
    function automatic logic [63:0] mix_step1(input logic [63:0] z);
        return (z ^ (z >> 30)) * 64'hbf58476d1ce4e5b9;
    endfunction

    function automatic logic [63:0] mix_step2(input logic [63:0] z);
        return (z ^ (z >> 27)) * 64'h94d049bb133111eb;
    endfunction

    function automatic logic [63:0] mix_step3(input logic [63:0] z);
        return z ^ (z >> 31);
    endfunction

    // ---------------------------------------------------------------------
    // Shared control
    // ---------------------------------------------------------------------
    logic [63:0] state_q;
    logic [63:0] state_d;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        out_valid_q;
    logic [W-1:0] out_data_q;

    logic        adv;
    logic        issue;
    logic        accept;
    logic [63:0] lane_in [LANES];

    // The whole pipeline moves only when the output slot is free or draining.
    assign adv    = ~out_valid_q | bus.out_ready;
    assign issue  = bus.run & adv & ~bus.seed_load;
    // An accept is counted even when seed_load flushes in the same cycle.
    assign accept = out_valid_q & bus.out_ready;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_in[i] = state_q + GAMMA * 64'(i + 1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.seed_load) begin
            state_d = bus.seed_in;
        end else if (issue) begin
            state_d = state_q + STEP;
        end
    end

    always_comb begin
        count_d = count_q;
        if (accept) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_DEFAULT;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------------
    // Mixer datapath
    // ---------------------------------------------------------------------
    if (PIPELINED == 0) begin : g_single
        logic [W-1:0] mix_d;

        always_comb begin
            mix_d = '0;
            for (int i = 0; i < LANES; i++) begin
                mix_d[64*i +: 64] = mix_step3(mix_step2(mix_step1(lane_in[i])));
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else if (bus.seed_load) begin
                // Flush; out_data keeps its last value but is no longer valid.
                out_valid_q <= 1'b0;
            end else if (adv) begin
                out_valid_q <= issue;
                if (issue) begin
                    out_data_q <= mix_d;
                end
            end
        end
    end else begin : g_pipe
        logic         v1_q;
        logic         v2_q;
        logic [W-1:0] s1_q;
        logic [W-1:0] s2_q;
        logic [W-1:0] s1_d;
        logic [W-1:0] s2_d;
        logic [W-1:0] s3_d;

        always_comb begin
            s1_d = '0;
            s2_d = '0;
            s3_d = '0;
            for (int i = 0; i < LANES; i++) begin
                s1_d[64*i +: 64] = mix_step1(lane_in[i]);
                s2_d[64*i +: 64] = mix_step2(s1_q[64*i +: 64]);
                s3_d[64*i +: 64] = mix_step3(s2_q[64*i +: 64]);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q        <= 1'b0;
                v2_q        <= 1'b0;
                s1_q        <= '0;
                s2_q        <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else if (bus.seed_load) begin
                v1_q        <= 1'b0;
                v2_q        <= 1'b0;
                out_valid_q <= 1'b0;
            end else if (adv) begin
                v1_q        <= issue;
                v2_q        <= v1_q;
                out_valid_q <= v2_q;
                // Data registers only load behind a valid bit, so bubbles
                // leave the last word in place.
                if (issue) begin
                    s1_q <= s1_d;
                end
                if (v1_q) begin
                    s2_q <= s2_d;
                end
                if (v2_q) begin
                    out_data_q <= s3_d;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = count_q;

endmodule

// File: tb/tb_splitmix64_gen.sv
// -----------------------------------------------------------------------------
// tb_splitmix64_gen
//   Drives two generators with the same control stimulus:
//     u_dut0 : LANES=1, PIPELINED=0
//     u_dut1 : LANES=2, PIPELINED=1
//   A reference model built from the SplitMix64 definition tracks, per DUT,
//   the current seed and the index of the next word to be accepted, and the
//   expected accept count.
// -----------------------------------------------------------------------------
module tb_splitmix64_gen;

    localparam logic [63:0] GAMMA = 64'h9e3779b97f4a7c15;
    localparam logic [63:0] W1    = 64'hE220A8397B1DCDAF;
    localparam logic [63:0] W2    = 64'h6E789E6AA1B965F4;
    localparam logic [63:0] W3    = 64'h06C45D188009454F;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    splitmix64_gen_if #(.LANES(1)) if0 ();
    splitmix64_gen_if #(.LANES(2)) if1 ();

    splitmix64_gen #(.LANES(1), .PIPELINED(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.master)
    );

    splitmix64_gen #(.LANES(2), .PIPELINED(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.master)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_mix(input logic [63:0] x);
        logic [63:0] z;
        z = x;
        z = (z ^ (z >> 30)) * 64'hbf58476d1ce4e5b9;
        z = (z ^ (z >> 27)) * 64'h94d049bb133111eb;
        z = z ^ (z >> 31);
        return z;
    endfunction

    // k-th word of the stream started from seed (k counts from 1).
    function automatic logic [63:0] ref_word(input logic [63:0] seed, input logic [63:0] k);
        return ref_mix(seed + k * GAMMA);
    endfunction

    logic [63:0] m_seed [2];
    logic [63:0] m_k    [2];
    logic [31:0] m_cnt  [2];
    int          m_acc  [2];
    int          idle;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_seed[d] = 64'h0;
            m_k[d]    = 64'h0;
            m_cnt[d]  = 32'h0;
        end
        idle = 0;
    endtask

    // Scoreboard step for one DUT across one clock edge.
    task automatic score(input int d, input int lanes,
                         input logic v, input logic [127:0] dat,
                         input logic sl, input logic [63:0] sin, input logic rdy,
                         input logic vn, input logic [127:0] datn, input logic [31:0] cntn);
        if (v && rdy) begin
            for (int i = 0; i < lanes; i++) begin
                check($sformatf("dut%0d_lane%0d_word", d, i), 128'(dat[64*i +: 64]),
                      128'(ref_word(m_seed[d], m_k[d] + 64'(i + 1))));
            end
            m_k[d]   = m_k[d] + 64'(lanes);
            m_cnt[d] = m_cnt[d] + 32'd1;
            m_acc[d] = m_acc[d] + 1;
        end
        if (sl) begin
            m_seed[d] = sin;
            m_k[d]    = 64'h0;
            check($sformatf("dut%0d_flush_valid", d), 128'(vn), 128'(0));
        end else if (v && !rdy) begin
            check($sformatf("dut%0d_hold_valid", d), 128'(vn), 128'(1));
            check($sformatf("dut%0d_hold_data", d), datn, dat);
        end
        check($sformatf("dut%0d_count", d), 128'(cntn), 128'(m_cnt[d]));
        if (idle >= 4) check($sformatf("dut%0d_drained", d), 128'(vn), 128'(0));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic sl, input logic [63:0] sin, input logic r, input logic rdy);
        if0.seed_load = sl;  if0.seed_in = sin;  if0.run = r;  if0.out_ready = rdy;
        if1.seed_load = sl;  if1.seed_in = sin;  if1.run = r;  if1.out_ready = rdy;
    endtask

    // One clock: capture pre-edge values, wait to the next falling edge,
    // then score both DUTs.
    task automatic tick();
        logic         v0, v1, sl, r, rdy;
        logic [127:0] d0, d1;
        logic [63:0]  sin;
        v0  = if0.out_valid;  d0 = 128'(if0.out_data);
        v1  = if1.out_valid;  d1 = 128'(if1.out_data);
        sl  = if0.seed_load;  sin = if0.seed_in;
        r   = if0.run;        rdy = if0.out_ready;
        @(negedge clk);
        if (!sl && !r && rdy) idle++;
        else idle = 0;
        score(0, 1, v0, d0, sl, sin, rdy, if0.out_valid, 128'(if0.out_data), if0.out_count);
        score(1, 2, v1, d1, sl, sin, rdy, if1.out_valid, 128'(if1.out_data), if1.out_count);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] cnt_before0;
    logic [31:0] cnt_before1;

    initial begin
        m_acc[0] = 0;
        m_acc[1] = 0;
        model_reset();
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_valid0", 128'(if0.out_valid), 128'(0));
        check("rst_valid1", 128'(if1.out_valid), 128'(0));
        check("rst_data0",  128'(if0.out_data),  128'(0));
        check("rst_data1",  128'(if1.out_data),  128'(0));
        check("rst_count0", 128'(if0.out_count), 128'(0));
        check("rst_count1", 128'(if1.out_count), 128'(0));
        rst_n = 1'b1;
        tick();

        // Latency and known-answer words from seed 0
        drive(1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        check("lat_valid0",  128'(if0.out_valid), 128'(1));
        check("kat_w1_dut0", 128'(if0.out_data),  128'(W1));
        check("lat_early1",  128'(if1.out_valid), 128'(0));
        tick();
        check("kat_w2_dut0", 128'(if0.out_data),  128'(W2));
        check("lat_early1b", 128'(if1.out_valid), 128'(0));
        tick();
        check("kat_w3_dut0", 128'(if0.out_data),  128'(W3));
        check("lat_valid1",  128'(if1.out_valid), 128'(1));
        check("kat_beat1_dut1", 128'(if1.out_data), {W2, W1});
        tick();
        check("tput_valid1", 128'(if1.out_valid), 128'(1));
        check("kat_beat2_lane0_dut1", 128'(if1.out_data[63:0]), 128'(W3));
        repeat (4) tick();

        // Backpressure for 5 cycles mid-stream
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        repeat (5) tick();
        drive(1'b0, 64'h0, 1'b1, 1'b1);
        repeat (10) tick();

        // seed_load of 0 while a beat is pending
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        repeat (3) tick();
        cnt_before0 = if0.out_count;
        cnt_before1 = if1.out_count;
        drive(1'b1, 64'h0, 1'b1, 1'b0);
        tick();
        check("sl_valid0", 128'(if0.out_valid), 128'(0));
        check("sl_valid1", 128'(if1.out_valid), 128'(0));
        check("sl_count0", 128'(if0.out_count), 128'(cnt_before0));
        check("sl_count1", 128'(if1.out_count), 128'(cnt_before1));
        drive(1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        check("sl_restart_dut0", 128'(if0.out_data), 128'(W1));
        repeat (2) tick();
        check("sl_restart_dut1", 128'(if1.out_data), {W2, W1});
        repeat (3) tick();

        // Accept counter wrap via backdoor preset
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        repeat (2) tick();
        force u_dut0.count_q = 32'hFFFF_FFFF;
        force u_dut1.count_q = 32'hFFFF_FFFF;
        #1;
        release u_dut0.count_q;
        release u_dut1.count_q;
        m_cnt[0] = 32'hFFFF_FFFF;
        m_cnt[1] = 32'hFFFF_FFFF;
        drive(1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        check("wrap_count0", 128'(if0.out_count), 128'(0));
        check("wrap_count1", 128'(if1.out_count), 128'(0));
        repeat (3) tick();

        // Asynchronous reset between clock edges, mid-pipeline
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid0", 128'(if0.out_valid), 128'(0));
        check("arst_valid1", 128'(if1.out_valid), 128'(0));
        check("arst_count0", 128'(if0.out_count), 128'(0));
        check("arst_count1", 128'(if1.out_count), 128'(0));
        model_reset();
        #1;
        rst_n = 1'b1;
        tick();
        check("arst_restart_dut0", 128'(if0.out_data), 128'(W1));
        repeat (3) tick();

        // Randomized control traffic
        for (int n = 0; n < 1500; n++) begin
            logic        r, rdy, sl;
            logic [63:0] sin;
            r   = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 7);
            sl  = ($urandom_range(0, 49) == 0);
            sin = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            if ($urandom_range(0, 99) < 3) begin
                r   = 1'b0;
                rdy = 1'b1;
            end
            drive(sl, sin, r, rdy);
            tick();
        end

        // Drain with run low
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        repeat (6) tick();

        check("activity_dut0", 128'(m_acc[0] > 500), 128'(1));
        check("activity_dut1", 128'(m_acc[1] > 500), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/splitmix64_gen.md
Name: splitmix64_gen

Overview:
- Self-contained, parametrised SplitMix64 generator. Holds its own 64-bit state, supports seed load, and produces LANES consecutive SplitMix64 words per beat.
- Mixer runs either in a single cycle or as a 3-stage pipeline.
- Output uses a valid/ready handshake with full backpressure.
- Sits upstream of the PRNG consumers (elliptic-curve scalar/nonce generation) in place of the per-call combinational mixer.

Parameters:
- LANES, 1, number of consecutive SplitMix64 outputs per beat (1..4).
- PIPELINED, 0, 0 = mixer in 1 stage; 1 = mixer split over 3 register stages.
- GAMMA, 64'h9e3779b97f4a7c15, state increment per generated word.
- SEED_DEFAULT, 64'h0, state value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seed_load  input  1  load seed_in into state and flush pipeline.
- seed_in  input  64  new seed.
- run  input  1  allow generation of new beats.
- out_ready  input  1  consumer accepts current beat.
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  64*LANES  lane i in bits [64*i+63:64*i]; lane 0 is the oldest word.
- out_count  output  32  number of accepted beats (out_valid & out_ready), wraps.

Behaviour:
- Reset (rst_n low, async): state = SEED_DEFAULT; all pipeline valid bits = 0; out_valid = 0; out_data = 0; out_count = 0.
- Mix function, all arithmetic mod 2^64, with multiply applied after the XOR:
  - z = (z ^ (z>>30)) * 64'hbf58476d1ce4e5b9
  - z = (z ^ (z>>27)) * 64'h94d049bb133111eb
  - z = z ^ (z>>31)
- Lane i input is state + (i+1)*GAMMA.
- Stall rule: adv = ~out_valid | out_ready. The whole pipeline, including the state update, moves only when adv = 1. With adv = 0, every stage register, out_data and out_valid hold unchanged.
- Issue rule: a beat issues in a cycle when run & adv & ~seed_load. On issue, state <= state + LANES*GAMMA and the stage-0 valid bit is set. When adv = 1 and no issue occurs, the stage-0 valid bit is cleared (bubble).
- Latency, issue cycle to out_valid:
  - PIPELINED = 0: 1 cycle (mix and register in one clock).
  - PIPELINED = 1: 3 cycles.
  - Stage split for PIPELINED = 1: stage 1 = add + first xor-shift-multiply; stage 2 = second xor-shift-multiply; stage 3 = final xor-shift into the output register.
- Throughput: 1 beat/cycle while run = 1 and out_ready = 1.
- Handshake:
  - out_data must be stable while out_valid = 1 and out_ready = 0.
  - A beat is consumed on a cycle with out_valid & out_ready.
  - out_valid may rise regardless of out_ready.
- out_count increments by 1 on each accepted beat; 32'hFFFFFFFF wraps to 0.
- seed_load:
  - Next cycle: state = seed_in; all valid bits (including out_valid) = 0. out_data holds its last value but is not valid.
  - seed_load has priority over run and over a pending un-accepted beat; that beat is discarded and not counted.
  - out_count is not cleared by seed_load.
- Simultaneous seed_load & out_ready with out_valid = 1: the beat counts as accepted (out_count++), then the flush takes effect.
- run deasserted: in-flight beats drain normally; state frozen.
- State wrap past 2^64 is silent modular arithmetic.
- Reset mid-operation: immediate return to reset values; in-flight beats lost.

Test Plan:
- LANES=1, PIPELINED=0, reset, run=1, out_ready=1 -> out_valid at cycle 1; out_data sequence 64'hE220A8397B1DCDAF, 64'h6E789E6AA1B965F4, 64'h06C45D188009454F; out_count 1, 2, 3.
- LANES=2, PIPELINED=1, seed 0 -> first beat 3 cycles after first issue, lane0=E220A8397B1DCDAF, lane1=6E789E6AA1B965F4; second beat lane0=06C45D188009454F; continuous 1 beat/cycle thereafter.
- Backpressure: out_ready low for 5 cycles mid-stream (PIPELINED=1) -> out_data frozen, no word skipped or duplicated after release; sequence identical to unstalled reference model.
- seed_load of 64'h0 while out_valid=1 & out_ready=0 -> out_valid=0 next cycle, pending beat dropped, out_count unchanged; resumed stream restarts at E220A8397B1DCDAF.
- rst_n pulsed low asynchronously mid-pipeline (between clock edges) -> out_valid and out_count 0 immediately; after release, sequence restarts from SEED_DEFAULT.
- Force out_count to 32'hFFFFFFFF via 2^32 accepts (or backdoor) -> next accept gives 0.
